stepdown_tstate_gen: RTL

- Generates the Tstate conduction-window signal for the step-down loop control.
- Tstate is consumed by the loop-control gating cells, where the output equals a control input AND Tstate.
- Turns a loop comparator demand into timed on-windows with leading-edge blanking, programmable on-time, early termination and a guaranteed minimum off-time.

---
 rtl/stepdown_tstate_gen_if.sv | 26 ++
 rtl/stepdown_tstate_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/stepdown_tstate_gen_if.sv
// Control/status bundle for stepdown_tstate_gen: demand, termination, on-time load and window status.
// master drives the loop demand side, slave is the window generator.
interface stepdown_tstate_gen_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             req;
    logic             term;
    logic [CNT_W-1:0] ton_cfg;
    logic             ton_load;
    logic             Tstate;
    logic             blank;
    logic             cycle_done;
    logic             busy;
    logic             fault;

    modport master (
        output en, req, term, ton_cfg, ton_load,
        input  Tstate, blank, cycle_done, busy, fault
    );

    modport slave (
        input  en, req, term, ton_cfg, ton_load,
        output Tstate, blank, cycle_done, busy, fault
    );
endinterface

// File: rtl/stepdown_tstate_gen.sv
// Tstate conduction-window generator: blanking, programmable on-time, early term, min off-time; STEPDOWN_TSTATE_FAULT_EN adds repeated-term fault.
// Latency: req sampled in IDLE gives Tstate=1 next cycle; all outputs registered from next state.
// No backpressure: req is ignored outside IDLE (and while fault=1); ton_load outside IDLE is held until IDLE entry.
module stepdown_tstate_gen #(
    parameter int CNT_W     = 8,
    parameter int TON_DEF   = 40,
    parameter int TBLANK    = 4,
    parameter int TOFF_MIN  = 6,
    parameter int FAULT_CNT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                CELV,
    input  logic                CELG,
    input  logic                SUB,
    stepdown_tstate_gen_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_ON    = 2'd2;
    localparam logic [1:0] S_OFF   = 2'd3;

    localparam logic [CNT_W-1:0] TON_MIN   = CNT_W'(TBLANK + 1);
    localparam logic [CNT_W-1:0] TON_RST   = (TON_DEF < TBLANK + 1) ? TON_MIN : CNT_W'(TON_DEF);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(TBLANK);
    localparam logic [CNT_W-1:0] OFF_END   = CNT_W'(TOFF_MIN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    function automatic logic [CNT_W-1:0] clamp_ton(input logic [CNT_W-1:0] v);
        return (v < TON_MIN) ? TON_MIN : v;
    endfunction

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [CNT_W-1:0] ton_reg, pend_val;
    logic             pend_vld;
    logic             end_term, end_expire, idle_entry;
    logic             fault_q;
    logic             unused_supply;

    assign unused_supply = ^{CELV, CELG, SUB};

    // cnt holds the 1-based index of the current Tstate (or OFF) cycle
    assign cnt_inc    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    assign idle_entry = (state == S_OFF) && (state_nxt == S_IDLE);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        end_term   = 1'b0;
        end_expire = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.en && bus.req && !fault_q) begin
                    state_nxt = S_BLANK;
                    cnt_nxt   = CNT_ONE;
                end
            end
            S_BLANK: begin
                if (!bus.en) begin
                    state_nxt = S_OFF;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    if (cnt >= BLANK_END) state_nxt = S_ON;
                    cnt_nxt = cnt_inc;
                end
            end
            S_ON: begin
                if (!bus.en) begin
                    state_nxt = S_OFF;
                    cnt_nxt   = CNT_ONE;
                end else if (bus.term) begin
                    // term wins over a coinciding expiry, so that window counts as terminated
                    state_nxt = S_OFF;
                    cnt_nxt   = CNT_ONE;
                    end_term  = 1'b1;
                end else if (cnt >= ton_reg) begin
                    state_nxt  = S_OFF;
                    cnt_nxt    = CNT_ONE;
                    end_expire = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_OFF: begin
                if (cnt >= OFF_END) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            bus.Tstate     <= 1'b0;
            bus.blank      <= 1'b0;
            bus.busy       <= 1'b0;
            bus.cycle_done <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            bus.Tstate     <= (state_nxt == S_BLANK) || (state_nxt == S_ON);
            bus.blank      <= (state_nxt == S_BLANK);
            bus.busy       <= (state_nxt != S_IDLE);
            bus.cycle_done <= idle_entry;
        end
    end

    // A running window always finishes on the on-time it started with
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ton_reg  <= TON_RST;
            pend_vld <= 1'b0;
            pend_val <= '0;
        end else if (state == S_IDLE) begin
            if (bus.ton_load) ton_reg <= clamp_ton(bus.ton_cfg);
            pend_vld <= 1'b0;
        end else if (idle_entry) begin
            if (bus.ton_load)  ton_reg <= clamp_ton(bus.ton_cfg);
            else if (pend_vld) ton_reg <= clamp_ton(pend_val);
            pend_vld <= 1'b0;
        end else if (bus.ton_load) begin
            pend_vld <= 1'b1;
            pend_val <= bus.ton_cfg;
        end
    end

`ifdef STEPDOWN_TSTATE_FAULT_EN
    localparam int           FW        = $clog2(FAULT_CNT + 1);
    localparam logic [FW-1:0] FAULT_LIM = FW'(FAULT_CNT);

    logic [FW-1:0] tcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt    <= '0;
            fault_q <= 1'b0;
        end else if (!bus.en) begin
            tcnt    <= '0;
            fault_q <= 1'b0;
        end else begin
            if (end_term && (tcnt != FAULT_LIM)) tcnt <= tcnt + 1'b1;
            else if (end_expire)                 tcnt <= '0;
            if (idle_entry && (tcnt >= FAULT_LIM)) fault_q <= 1'b1;
        end
    end
`else
    logic        unused_nofault;
    logic [31:0] unused_fault_cnt;

    assign unused_fault_cnt = 32'(FAULT_CNT);
    assign unused_nofault   = ^{end_term, end_expire, unused_fault_cnt};
    assign fault_q          = 1'b0;
`endif

    assign bus.fault = fault_q;
endmodule
